// File: rtl/or1420_exe_pkg.sv
// Shared definitions for the or1420 execute-side operand stage: opcodes,
// register-zero index, scoreboard state encoding and immediate extension.
package or1420_exe_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned IMM_WIDTH  = 16;
  localparam int unsigned OPC_WIDTH  = 3;

  localparam logic [OPC_WIDTH-1:0] AND   = 3'b001;
  localparam logic [OPC_WIDTH-1:0] OR    = 3'b010;
  localparam logic [OPC_WIDTH-1:0] XOR   = 3'b011;
  localparam logic [OPC_WIDTH-1:0] EXTHS = 3'b100;
  localparam logic [OPC_WIDTH-1:0] EXTBS = 3'b101;
  localparam logic [OPC_WIDTH-1:0] EXTHZ = 3'b110;
  localparam logic [OPC_WIDTH-1:0] EXTBZ = 3'b111;

  localparam int unsigned REG_ZERO = 0;

  localparam logic [0:0] SB_IDLE      = 1'b0;
  localparam logic [0:0] SB_LOAD_WAIT = 1'b1;

  // Sign- or zero-extend the 16-bit immediate field to the data width.
  function automatic logic [DATA_WIDTH-1:0] extend_imm(input logic [IMM_WIDTH-1:0] imm,
                                                       input logic               sign_ext);
    if (sign_ext) return {{(DATA_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
    return {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/operand_forward_mux.sv
// Per-source operand selection: r0, execute bypass, writeback bypass, then
// register file, in that priority.
module operand_forward_mux
  import or1420_exe_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] src,
  input  logic [DATA_WIDTH-1:0]     rf_data,
  input  logic                      fwd_exe_valid,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_exe_dest,
  input  logic [DATA_WIDTH-1:0]     fwd_exe_data,
  input  logic                      fwd_wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_wb_dest,
  input  logic [DATA_WIDTH-1:0]     fwd_wb_data,
  output logic [DATA_WIDTH-1:0]     operand_c
);

  always_comb begin
    operand_c = rf_data;
    if (src == REG_ADDR_WIDTH'(REG_ZERO)) begin
      operand_c = '0;
    end else if (fwd_exe_valid && (fwd_exe_dest == src)) begin
      operand_c = fwd_exe_data;
    end else if (fwd_wb_valid && (fwd_wb_dest == src)) begin
      operand_c = fwd_wb_data;
    end
  end

endmodule

// File: rtl/exe_operand_stage.sv
// Operand resolution stage feeding the execute units, with a one-entry load
// scoreboard. Optional hazard-stall counter under EXE_OPERAND_STALL_COUNT_EN.
module exe_operand_stage
  import or1420_exe_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5
`ifdef EXE_OPERAND_STALL_COUNT_EN
  , parameter int unsigned STALL_CNT_WIDTH = 32
`endif
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      stall_in,
  input  logic                      flush,
  input  logic                      dec_valid,
  output logic                      dec_ready,
  input  logic [OPC_WIDTH-1:0]      dec_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] dec_srcA,
  input  logic [REG_ADDR_WIDTH-1:0] dec_srcB,
  input  logic                      dec_useImm,
  input  logic                      dec_immSigned,
  input  logic [IMM_WIDTH-1:0]      dec_imm,
  input  logic [REG_ADDR_WIDTH-1:0] dec_dest,
  input  logic                      dec_writeEn,
  input  logic                      dec_isLoad,
  input  logic [DATA_WIDTH-1:0]     rf_dataA,
  input  logic [DATA_WIDTH-1:0]     rf_dataB,
  input  logic                      fwd_exe_valid,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_exe_dest,
  input  logic [DATA_WIDTH-1:0]     fwd_exe_data,
  input  logic                      fwd_wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_wb_dest,
  input  logic [DATA_WIDTH-1:0]     fwd_wb_data,
  input  logic                      load_done,
  output logic                      exe_valid,
  output logic [OPC_WIDTH-1:0]      exe_opcode,
  output logic [DATA_WIDTH-1:0]     exe_operantA,
  output logic [DATA_WIDTH-1:0]     exe_operantB,
  output logic [REG_ADDR_WIDTH-1:0] exe_dest,
  output logic                      exe_writeEn,
  output logic                      exe_isLoad
`ifdef EXE_OPERAND_STALL_COUNT_EN
  , input  logic                       stall_count_clear
  , output logic [STALL_CNT_WIDTH-1:0] stall_count
`endif
);

  logic [0:0]                state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0] pend_dest_q, pend_dest_d;
  logic                      hazard_c, accept_c, load_issue_c;
  logic [DATA_WIDTH-1:0]     opa_c, opb_reg_c, opb_c;

  operand_forward_mux #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_mux_a (
    .src          (dec_srcA),
    .rf_data      (rf_dataA),
    .fwd_exe_valid(fwd_exe_valid),
    .fwd_exe_dest (fwd_exe_dest),
    .fwd_exe_data (fwd_exe_data),
    .fwd_wb_valid (fwd_wb_valid),
    .fwd_wb_dest  (fwd_wb_dest),
    .fwd_wb_data  (fwd_wb_data),
    .operand_c    (opa_c)
  );

  operand_forward_mux #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_mux_b (
    .src          (dec_srcB),
    .rf_data      (rf_dataB),
    .fwd_exe_valid(fwd_exe_valid),
    .fwd_exe_dest (fwd_exe_dest),
    .fwd_exe_data (fwd_exe_data),
    .fwd_wb_valid (fwd_wb_valid),
    .fwd_wb_dest  (fwd_wb_dest),
    .fwd_wb_data  (fwd_wb_data),
    .operand_c    (opb_reg_c)
  );

  assign opb_c = dec_useImm ? extend_imm(dec_imm, dec_immSigned) : opb_reg_c;

  // Hazard looks at registered state only, so the load_done cycle still stalls.
  assign hazard_c = (state_q == SB_LOAD_WAIT) &&
                    ((dec_srcA == pend_dest_q) ||
                     (!dec_useImm && (dec_srcB == pend_dest_q)) ||
                     dec_isLoad);
  assign dec_ready    = !reset && !stall_in && !flush && !hazard_c;
  assign accept_c     = dec_valid && dec_ready;
  assign load_issue_c = accept_c && dec_isLoad && dec_writeEn &&
                        (dec_dest != REG_ADDR_WIDTH'(REG_ZERO));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= SB_IDLE;
      pend_dest_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_dest_q <= pend_dest_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_dest_d = pend_dest_q;
    case (state_q)
      SB_IDLE: begin
        if (load_issue_c) begin
          state_d     = SB_LOAD_WAIT;
          pend_dest_d = dec_dest;
        end
      end
      SB_LOAD_WAIT: begin
        if (load_issue_c) begin
          pend_dest_d = dec_dest;
        end else if (load_done) begin
          state_d = SB_IDLE;
        end
      end
      default: state_d = SB_IDLE;
    endcase
  end

  // Output register: flush beats stall, stall holds, idle drops valid only.
  always_ff @(posedge clock) begin
    if (reset) begin
      exe_valid    <= 1'b0;
      exe_opcode   <= '0;
      exe_operantA <= '0;
      exe_operantB <= '0;
      exe_dest     <= '0;
      exe_writeEn  <= 1'b0;
      exe_isLoad   <= 1'b0;
    end else if (flush) begin
      exe_valid <= 1'b0;
    end else if (stall_in) begin
      exe_valid <= exe_valid;
    end else if (accept_c) begin
      exe_valid    <= 1'b1;
      exe_opcode   <= dec_opcode;
      exe_operantA <= opa_c;
      exe_operantB <= opb_c;
      exe_dest     <= dec_dest;
      exe_writeEn  <= dec_writeEn;
      exe_isLoad   <= dec_isLoad;
    end else begin
      exe_valid <= 1'b0;
    end
  end

`ifdef EXE_OPERAND_STALL_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset || stall_count_clear) begin
      stall_count <= '0;
    end else if (dec_valid && hazard_c && !flush) begin
      stall_count <= stall_count + STALL_CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_exe_operand_stage.sv
// Self-checking bench for exe_operand_stage: directed scenarios followed by
// randomized traffic checked against a behavioural model.
module tb_exe_operand_stage;

  logic        clock = 1'b0;
  logic        reset, stall_in, flush, dec_valid, dec_ready;
  logic [2:0]  dec_opcode;
  logic [4:0]  dec_srcA, dec_srcB, dec_dest;
  logic        dec_useImm, dec_immSigned, dec_writeEn, dec_isLoad;
  logic [15:0] dec_imm;
  logic [31:0] rf_dataA, rf_dataB;
  logic        fwd_exe_valid, fwd_wb_valid, load_done;
  logic [4:0]  fwd_exe_dest, fwd_wb_dest;
  logic [31:0] fwd_exe_data, fwd_wb_data;
  logic        exe_valid, exe_writeEn, exe_isLoad;
  logic [2:0]  exe_opcode;
  logic [31:0] exe_operantA, exe_operantB;
  logic [4:0]  exe_dest;
`ifdef EXE_OPERAND_STALL_COUNT_EN
  logic        stall_count_clear;
  logic [31:0] stall_count;
`endif

  exe_operand_stage dut (
    .clock(clock), .reset(reset), .stall_in(stall_in), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_opcode(dec_opcode),
    .dec_srcA(dec_srcA), .dec_srcB(dec_srcB), .dec_useImm(dec_useImm),
    .dec_immSigned(dec_immSigned), .dec_imm(dec_imm), .dec_dest(dec_dest),
    .dec_writeEn(dec_writeEn), .dec_isLoad(dec_isLoad),
    .rf_dataA(rf_dataA), .rf_dataB(rf_dataB),
    .fwd_exe_valid(fwd_exe_valid), .fwd_exe_dest(fwd_exe_dest), .fwd_exe_data(fwd_exe_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_dest(fwd_wb_dest), .fwd_wb_data(fwd_wb_data),
    .load_done(load_done), .exe_valid(exe_valid), .exe_opcode(exe_opcode),
    .exe_operantA(exe_operantA), .exe_operantB(exe_operantB), .exe_dest(exe_dest),
    .exe_writeEn(exe_writeEn), .exe_isLoad(exe_isLoad)
`ifdef EXE_OPERAND_STALL_COUNT_EN
    , .stall_count_clear(stall_count_clear), .stall_count(stall_count)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit          m_valid, m_we, m_ld, m_pend;
  logic [2:0]  m_opc;
  logic [31:0] m_a, m_b, m_cnt;
  logic [4:0]  m_dest, m_pd;
  logic        last_ready;
  logic [31:0] saved_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] resolve(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) return 32'd0;
    if (fwd_exe_valid && fwd_exe_dest == idx) return fwd_exe_data;
    if (fwd_wb_valid && fwd_wb_dest == idx) return fwd_wb_data;
    return rf;
  endfunction

  task automatic idle_inputs();
    reset = 0; stall_in = 0; flush = 0; dec_valid = 0; dec_opcode = 0;
    dec_srcA = 0; dec_srcB = 0; dec_useImm = 0; dec_immSigned = 0; dec_imm = 0;
    dec_dest = 0; dec_writeEn = 0; dec_isLoad = 0; rf_dataA = 0; rf_dataB = 0;
    fwd_exe_valid = 0; fwd_exe_dest = 0; fwd_exe_data = 0;
    fwd_wb_valid = 0; fwd_wb_dest = 0; fwd_wb_data = 0; load_done = 0;
`ifdef EXE_OPERAND_STALL_COUNT_EN
    stall_count_clear = 0;
`endif
  endtask

  task automatic instr(input logic [2:0] opc, input logic [4:0] a, input logic [4:0] b,
                       input logic use_imm, input logic sgn, input logic [15:0] imm,
                       input logic [4:0] dest, input logic we, input logic ld);
    dec_valid = 1; dec_opcode = opc; dec_srcA = a; dec_srcB = b; dec_useImm = use_imm;
    dec_immSigned = sgn; dec_imm = imm; dec_dest = dest; dec_writeEn = we; dec_isLoad = ld;
  endtask

  task automatic random_inputs();
    reset = ($urandom_range(0, 99) == 0);
    stall_in = ($urandom_range(0, 7) == 0);
    flush = ($urandom_range(0, 15) == 0);
    dec_valid = ($urandom_range(0, 3) != 0);
    dec_opcode = 3'($urandom);
    dec_srcA = 5'($urandom_range(0, 7));
    dec_srcB = 5'($urandom_range(0, 7));
    dec_useImm = 1'($urandom);
    dec_immSigned = 1'($urandom);
    dec_imm = 16'($urandom);
    dec_dest = 5'($urandom_range(0, 7));
    dec_writeEn = 1'($urandom);
    dec_isLoad = ($urandom_range(0, 3) == 0);
    rf_dataA = $urandom; rf_dataB = $urandom;
    fwd_exe_valid = 1'($urandom); fwd_exe_dest = 5'($urandom_range(0, 7)); fwd_exe_data = $urandom;
    fwd_wb_valid = 1'($urandom); fwd_wb_dest = 5'($urandom_range(0, 7)); fwd_wb_data = $urandom;
    load_done = ($urandom_range(0, 3) == 0);
`ifdef EXE_OPERAND_STALL_COUNT_EN
    stall_count_clear = ($urandom_range(0, 63) == 0);
`endif
  endtask

  // One clock: check ready, advance model at the edge, check registered outputs.
  task automatic cycle();
    bit haz, rdy, acc;
    haz = m_pend && ((dec_srcA == m_pd) || (!dec_useImm && dec_srcB == m_pd) || dec_isLoad);
    rdy = !reset && !stall_in && !flush && !haz;
    acc = dec_valid && rdy;
    #1;
    check("dec_ready", 32'(dec_ready), 32'(rdy));
    last_ready = dec_ready;
    @(posedge clock);
    if (reset) begin
      m_valid = 0; m_opc = 0; m_a = 0; m_b = 0; m_dest = 0; m_we = 0; m_ld = 0;
      m_pend = 0; m_pd = 0; m_cnt = 0;
    end else begin
`ifdef EXE_OPERAND_STALL_COUNT_EN
      if (stall_count_clear) m_cnt = 0;
      else if (dec_valid && haz && !flush) m_cnt = m_cnt + 1;
`endif
      if (flush) m_valid = 0;
      else if (stall_in) m_valid = m_valid;
      else if (acc) begin
        m_valid = 1; m_opc = dec_opcode; m_a = resolve(dec_srcA, rf_dataA);
        m_b = !dec_useImm ? resolve(dec_srcB, rf_dataB) :
              dec_immSigned ? 32'($signed(dec_imm)) : {16'd0, dec_imm};
        m_dest = dec_dest; m_we = dec_writeEn; m_ld = dec_isLoad;
      end else m_valid = 0;
      if (acc && dec_isLoad && dec_writeEn && dec_dest != 0) begin
        m_pend = 1; m_pd = dec_dest;
      end else if (m_pend && load_done) m_pend = 0;
    end
    #1;
    check("exe_valid", 32'(exe_valid), 32'(m_valid));
    check("exe_opcode", 32'(exe_opcode), 32'(m_opc));
    check("exe_operantA", exe_operantA, m_a);
    check("exe_operantB", exe_operantB, m_b);
    check("exe_dest", 32'(exe_dest), 32'(m_dest));
    check("exe_writeEn", 32'(exe_writeEn), 32'(m_we));
    check("exe_isLoad", 32'(exe_isLoad), 32'(m_ld));
`ifdef EXE_OPERAND_STALL_COUNT_EN
    check("stall_count", stall_count, m_cnt);
`endif
    @(negedge clock);
  endtask

  initial begin
    m_valid = 0; m_we = 0; m_ld = 0; m_pend = 0; m_opc = 0; m_a = 0; m_b = 0;
    m_cnt = 0; m_dest = 0; m_pd = 0; last_ready = 0; saved_a = 0;
    idle_inputs();
    reset = 1;
    @(negedge clock);
    cycle(); cycle();
    check("reset_valid", 32'(exe_valid), 32'd0);

    // Sign-extended immediate with rf operand A
    idle_inputs();
    instr(3'b011, 5'd3, 5'd0, 1, 1, 16'h8001, 5'd4, 1, 0);
    rf_dataA = 32'h0000_00F0;
    cycle();
    check("imm_opA", exe_operantA, 32'h0000_00F0);
    check("imm_opB", exe_operantB, 32'hFFFF_8001);
    check("imm_valid", 32'(exe_valid), 32'd1);

    // Execute bypass beats writeback; zero-extended immediate
    idle_inputs();
    instr(3'b001, 5'd5, 5'd0, 1, 0, 16'h8001, 5'd6, 1, 0);
    rf_dataA = 32'h1234_5678;
    fwd_exe_valid = 1; fwd_exe_dest = 5'd5; fwd_exe_data = 32'hAAAA_AAAA;
    fwd_wb_valid = 1; fwd_wb_dest = 5'd5; fwd_wb_data = 32'h5555_5555;
    cycle();
    check("fwd_prio", exe_operantA, 32'hAAAA_AAAA);
    check("zext_opB", exe_operantB, 32'h0000_8001);

    // r0 is never forwarded
    dec_srcA = 5'd0; fwd_exe_dest = 5'd0; fwd_exe_data = 32'hDEAD_BEEF;
    cycle();
    check("r0_opA", exe_operantA, 32'd0);

    // Load to r7, non-dependent issue, then load and dependent stalls
    idle_inputs();
    instr(3'b010, 5'd1, 5'd2, 0, 0, 16'd0, 5'd7, 1, 1);
    cycle();
    instr(3'b001, 5'd2, 5'd9, 0, 0, 16'd0, 5'd10, 1, 0);
    cycle();
    check("nondep_ready", 32'(last_ready), 32'd1);
    instr(3'b010, 5'd1, 5'd2, 0, 0, 16'd0, 5'd11, 1, 1);
    cycle(); cycle();
    check("second_load_ready", 32'(last_ready), 32'd0);
    instr(3'b011, 5'd1, 5'd7, 0, 0, 16'd0, 5'd8, 1, 0);
    cycle(); cycle();
    check("dep_ready", 32'(last_ready), 32'd0);
    load_done = 1;
    cycle();
    check("done_cycle_ready", 32'(last_ready), 32'd0);
    load_done = 0;
    cycle();
    check("resume_ready", 32'(last_ready), 32'd1);
`ifdef EXE_OPERAND_STALL_COUNT_EN
    check("stall_count_5", stall_count, 32'd5);
`endif

    // Hold under stall_in, then flush during stall
    saved_a = exe_operantA;
    instr(3'b100, 5'd3, 5'd4, 0, 0, 16'd0, 5'd12, 1, 0);
    rf_dataA = 32'hCAFE_0001;
    stall_in = 1;
    cycle(); cycle(); cycle();
    check("stall_hold_A", exe_operantA, saved_a);
    check("stall_hold_valid", 32'(exe_valid), 32'd1);
    flush = 1;
    cycle();
    check("flush_valid", 32'(exe_valid), 32'd0);
    check("flush_ready", 32'(last_ready), 32'd0);
    flush = 0; stall_in = 0; dec_valid = 0;
    cycle();
    check("flush_not_taken", 32'(exe_valid), 32'd0);

    // Reset during LOAD_WAIT with a live output
    idle_inputs();
    instr(3'b010, 5'd1, 5'd2, 0, 0, 16'd0, 5'd7, 1, 1);
    cycle();
    instr(3'b011, 5'd1, 5'd7, 0, 0, 16'd0, 5'd8, 1, 0);
    reset = 1;
    cycle();
    check("rst_mid_valid", 32'(exe_valid), 32'd0);
    reset = 0;
    cycle();
    check("rst_mid_ready", 32'(last_ready), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      random_inputs();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exe_operand_stage.md
Name: exe_operand_stage

Overview:
- Pipeline stage directly upstream of the or1420 logic unit and its sibling execute units: takes a decoded instruction, resolves both operands and registers opcode/operantA/operantB for the execute stage.
- Operand sources: register-file read data, immediate (sign- or zero-extended), or forwarded results from execute and writeback.
- Tracks one outstanding load in a scoreboard and stalls decode on load-use hazards.

Parameters:
REG_ADDR_WIDTH, 5, register index width (32 GPRs, r0 hardwired zero).
STALL_CNT_WIDTH, 32, width of the hazard-stall counter (optional feature only).

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
stall_in  in  1  execute stage cannot accept; hold output register
flush  in  1  squash the instruction offered this cycle and the output register
dec_valid  in  1  decode offers an instruction
dec_ready  out  1  stage accepts this cycle (combinational)
dec_opcode  in  3  execute-unit opcode, passed through
dec_srcA, dec_srcB  in  REG_ADDR_WIDTH  source register indices
dec_useImm  in  1  operantB comes from the immediate
dec_immSigned  in  1  1 = sign-extend dec_imm, 0 = zero-extend
dec_imm  in  16  immediate field
dec_dest  in  REG_ADDR_WIDTH  destination register
dec_writeEn  in  1  instruction writes dec_dest
dec_isLoad  in  1  instruction is a load
rf_dataA, rf_dataB  in  32  register-file read data for srcA/srcB
fwd_exe_valid, fwd_exe_dest, fwd_exe_data  in  1/REG_ADDR_WIDTH/32  execute-stage result bypass
fwd_wb_valid, fwd_wb_dest, fwd_wb_data  in  1/REG_ADDR_WIDTH/32  writeback bypass
load_done  in  1  outstanding load has written back
exe_valid  out  1  output register holds a live instruction
exe_opcode  out  3  registered opcode
exe_operantA, exe_operantB  out  32  registered operands
exe_dest  out  REG_ADDR_WIDTH  registered destination
exe_writeEn, exe_isLoad  out  1  registered control

Behaviour:
- Reset, synchronous, active-high, applies on any cycle including mid-stall:
  - exe_valid, exe_writeEn, exe_isLoad = 0.
  - exe_opcode, exe_operantA/B, exe_dest = 0.
  - Scoreboard busy = 0; state = IDLE.
- Latency: one cycle from accept to exe_valid.
- Operand resolution, per source, in priority order:
  - index 0 gives 0 and is never forwarded.
  - fwd_exe_valid && fwd_exe_dest==idx gives fwd_exe_data.
  - fwd_wb_valid && fwd_wb_dest==idx gives fwd_wb_data.
  - Otherwise the rf data.
- operantB = dec_useImm ? extended dec_imm : resolved srcB.
  - Sign extension replicates bit 15 into [31:16]; zero extension fills [31:16] with 0.
- Scoreboard FSM:
  - IDLE: on accept of dec_isLoad && dec_writeEn && dec_dest!=0, go to LOAD_WAIT and latch pendDest.
  - LOAD_WAIT: on load_done, go to IDLE.
  - Same-cycle load_done and a new load accept: stay in LOAD_WAIT and latch the new pendDest.
- hazard = LOAD_WAIT && ( (srcA==pendDest) || (!dec_useImm && srcB==pendDest) || dec_isLoad ).
  - Only one load may be outstanding.
  - hazard uses the registered state, so the cycle carrying load_done still stalls and issue resumes the cycle after.
- dec_ready = !reset && !stall_in && !flush && !hazard. Accept = dec_valid && dec_ready.
- Output register:
  - flush: exe_valid <= 0 (overrides stall_in).
  - else stall_in: hold all outputs.
  - else accept: load all outputs, exe_valid <= 1.
  - else: exe_valid <= 0, data fields hold.
- flush does not clear the scoreboard; an issued load still completes.

Optional Feature:
- Macro: EXE_OPERAND_STALL_COUNT_EN.
- Defined:
  - Extra output port stall_count (STALL_CNT_WIDTH) increments each cycle where dec_valid && hazard && !flush.
  - Wraps at all-ones to 0; cleared by reset.
  - Extra input stall_count_clear (1) zeroes it next cycle, with priority over the increment.
- Undefined: neither port exists and no counter logic is generated.

Decomposition:
- Shared package or1420_exe_pkg holds:
  - Opcode constants: AND=3'b001, OR=3'b010, XOR=3'b011, EXTHS=3'b100, EXTBS=3'b101, EXTHZ=3'b110, EXTBZ=3'b111.
  - REG_ZERO=0.
  - Scoreboard state encoding IDLE/LOAD_WAIT.
- Sub-module operand_forward_mux: the per-source zero/exe/wb/rf priority selection, instantiated twice (A and B).

Test Plan:
- Reset mid-LOAD_WAIT with exe_valid=1 -> next cycle exe_valid=0, state IDLE, dec_ready=1 once dec_valid is presented.
- Accept opcode 3'b011, srcA=3 (rf 0x0000_00F0), useImm, immSigned=1, imm=0x8001 -> next cycle exe_operantA=0x0000_00F0, exe_operantB=0xFFFF_8001, exe_valid=1.
- srcA=5 with fwd_exe(5,0xAAAA_AAAA) and fwd_wb(5,0x5555_5555) both valid -> operantA=0xAAAA_AAAA; srcA=0 with fwd_exe dest 0 -> operantA=0.
- Load to r7 accepted, then a dependent instruction with srcB=7 -> dec_ready=0 until the cycle after load_done, then accepted; with the macro defined, stall_count equals the number of stalled cycles.
- stall_in=1 for 3 cycles with exe_valid=1 -> outputs held; flush asserted during stall_in -> exe_valid=0 next cycle and the offered instruction is not accepted.
- Non-dependent instruction (srcA=2, srcB=9, pendDest=7) in LOAD_WAIT -> accepted without stall; a second load in LOAD_WAIT -> stalls.
